// File: rtl/ksa_pkg.sv
// ============================================================================
// ksa_pkg : operation codes and elaboration helpers for the pipelined KSA.
// Revision 1.0
// ============================================================================
`default_nettype none

package ksa_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int ksa_levels(input int width);
        return $clog2(width);
    endfunction

    // Accept-to-out_valid latency: input register + masked level registers + output register.
    function automatic int ksa_latency(input logic [31:0] mask);
        int n;
        n = 2;
        for (int k = 0; k < 32; k++) begin
            n += int'(mask[k]);
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ksa_prefix_cell.sv
// ============================================================================
// ksa_prefix_cell : Kogge-Stone black cell; acts as a gray cell when p_o is unused.
// Revision 1.0
// ============================================================================
`default_nettype none

module ksa_prefix_cell (
    input  logic g_hi_i,
    input  logic p_hi_i,
    input  logic g_lo_i,
    input  logic p_lo_i,
    output logic g_o,
    output logic p_o
);

    assign g_o = g_hi_i | (p_hi_i & g_lo_i);
    assign p_o = p_hi_i & p_lo_i;

endmodule

`default_nettype wire

// File: rtl/pipelined_ksa.sv
// ============================================================================
// pipelined_ksa : parametrised Kogge-Stone add/sub with optional per-level
// pipeline registers and valid/ready handshake under a global stall.
// Revision 1.0
// ============================================================================
`default_nettype none

module pipelined_ksa
    import ksa_pkg::*;
#(
    parameter int                           WIDTH    = 16,
    parameter logic [ksa_levels(WIDTH)-1:0] REG_MASK = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int LVL = ksa_levels(WIDTH);

    if (WIDTH < 2) begin : g_width_check
        $error("pipelined_ksa: WIDTH must be at least 2");
    end

    logic stall;
    logic out_valid_q;
    logic out_valid_d;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall;

    // ------------------------------------------------------------------
    // Stage 0: operand register with B inversion and carry-in selection
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] b_d;
    logic             c0_q;
    logic             c0_d;
    logic             v0_q;
    logic             v0_d;

    always_comb begin
        v0_d = v0_q;
        a_d  = a_q;
        b_d  = b_q;
        c0_d = c0_q;
        if (!stall) begin
            v0_d = in_valid;
            if (in_valid) begin
                a_d  = A;
                b_d  = (Op == OP_SUB) ? ~B : B;
                c0_d = (Op == OP_SUB) ? 1'b1 : Cin;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v0_q <= 1'b0;
            a_q  <= '0;
            b_q  <= '0;
            c0_q <= 1'b0;
        end else begin
            v0_q <= v0_d;
            a_q  <= a_d;
            b_q  <= b_d;
            c0_q <= c0_d;
        end
    end

    // Per-stage buses: index k is the input to prefix level k, index LVL the final carries.
    logic [WIDTH-1:0] g_s  [0:LVL];
    logic [WIDTH-1:0] p_s  [0:LVL];
    logic [WIDTH-1:0] po_s [0:LVL];
    logic             c0_s [0:LVL];
    logic             v_s  [0:LVL];

    logic [WIDTH-1:0] g_bit;
    logic [WIDTH-1:0] p_bit;
    logic [WIDTH-1:0] g_pre;
    logic [WIDTH-1:0] p_pre;

    assign g_bit = a_q & b_q;
    assign p_bit = a_q ^ b_q;

    // c0 is the generate of a virtual bit -1; bit 0 then carries a fully resolved group.
    ksa_prefix_cell u_pre_gray (
        .g_hi_i (g_bit[0]),
        .p_hi_i (p_bit[0]),
        .g_lo_i (c0_q),
        .p_lo_i (1'b0),
        .g_o    (g_pre[0]),
        .p_o    (p_pre[0])
    );

    assign g_pre[WIDTH-1:1] = g_bit[WIDTH-1:1];
    assign p_pre[WIDTH-1:1] = p_bit[WIDTH-1:1];

    assign g_s[0]  = g_pre;
    assign p_s[0]  = p_pre;
    assign po_s[0] = p_bit;
    assign c0_s[0] = c0_q;
    assign v_s[0]  = v0_q;

    // ------------------------------------------------------------------
    // Prefix network with optional register after each level
    // ------------------------------------------------------------------
    for (genvar k = 0; k < LVL; k++) begin : g_level
        localparam int SPAN = 1 << k;

        logic [WIDTH-1:0] lg;
        logic [WIDTH-1:0] lp;

        for (genvar i = 0; i < WIDTH; i++) begin : g_bit_col
            if (i >= SPAN) begin : g_cell
                ksa_prefix_cell u_cell (
                    .g_hi_i (g_s[k][i]),
                    .p_hi_i (p_s[k][i]),
                    .g_lo_i (g_s[k][i-SPAN]),
                    .p_lo_i (p_s[k][i-SPAN]),
                    .g_o    (lg[i]),
                    .p_o    (lp[i])
                );
            end else begin : g_pass
                assign lg[i] = g_s[k][i];
                assign lp[i] = p_s[k][i];
            end
        end

        if (REG_MASK[k]) begin : g_reg
            logic [WIDTH-1:0] g_q;
            logic [WIDTH-1:0] p_q;
            logic [WIDTH-1:0] po_q;
            logic             c0_lq;
            logic             v_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    g_q   <= '0;
                    p_q   <= '0;
                    po_q  <= '0;
                    c0_lq <= 1'b0;
                    v_q   <= 1'b0;
                end else if (!stall) begin
                    g_q   <= lg;
                    p_q   <= lp;
                    po_q  <= po_s[k];
                    c0_lq <= c0_s[k];
                    v_q   <= v_s[k];
                end
            end

            assign g_s[k+1]  = g_q;
            assign p_s[k+1]  = p_q;
            assign po_s[k+1] = po_q;
            assign c0_s[k+1] = c0_lq;
            assign v_s[k+1]  = v_q;
        end else begin : g_comb
            assign g_s[k+1]  = lg;
            assign p_s[k+1]  = lp;
            assign po_s[k+1] = po_s[k];
            assign c0_s[k+1] = c0_s[k];
            assign v_s[k+1]  = v_s[k];
        end
    end

    // ------------------------------------------------------------------
    // Output register: sum, carry out and signed overflow
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] gc;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             cout_q;
    logic             cout_d;
    logic             ovf_q;
    logic             ovf_d;

    assign gc = g_s[LVL];

    always_comb begin
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        if (!stall) begin
            out_valid_d = v_s[LVL];
            if (v_s[LVL]) begin
                sum_d  = po_s[LVL] ^ {gc[WIDTH-2:0], c0_s[LVL]};
                cout_d = gc[WIDTH-1];
                ovf_d  = gc[WIDTH-2] ^ gc[WIDTH-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_ksa.sv
// ============================================================================
// tb_pipelined_ksa : directed checks of a default 16-bit core and a
// registered 8-bit core (mask 3'b101).
// ============================================================================
`default_nettype none

module tb_pipelined_ksa;
    import ksa_pkg::*;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        op;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } res8_t;

    localparam logic [2:0] MASK8 = 3'b101;

    logic clk = 1'b0;
    logic reset;

    logic        in_valid16, in_ready16, cin16, op16, out_valid16, out_ready16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;
    logic        in_valid8, in_ready8, cin8, op8, out_valid8, out_ready8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs [11];

    always #5 clk = ~clk;

    pipelined_ksa u_dut16 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .A         (a16),
        .B         (b16),
        .Cin       (cin16),
        .Op        (op16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .Sum       (sum16),
        .Cout      (cout16),
        .Ovf       (ovf16)
    );

    pipelined_ksa #(.WIDTH(8), .REG_MASK(MASK8)) u_dut8 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .A         (a8),
        .B         (b8),
        .Cin       (cin8),
        .Op        (op8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .Sum       (sum8),
        .Cout      (cout8),
        .Ovf       (ovf8)
    );

    task automatic idle16();
        in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; op16 = OP_ADD;
    endtask

    task automatic idle8();
        in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; op8 = OP_ADD;
    endtask

    task automatic drive16(input vec_t v);
        in_valid16 = 1'b1; a16 = v.a; b16 = v.b; cin16 = v.cin; op16 = v.op;
    endtask

    task automatic init_vectors();
        vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, OP_ADD, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{16'h8000, 16'h0001, 1'b0, OP_SUB, 16'h7FFF, 1'b1, 1'b1};
        vecs[2]  = '{16'h0003, 16'h0005, 1'b0, OP_SUB, 16'hFFFE, 1'b0, 1'b0};
        vecs[3]  = '{16'h7FFF, 16'h0001, 1'b0, OP_ADD, 16'h8000, 1'b0, 1'b1};
        vecs[4]  = '{16'h1234, 16'h4321, 1'b1, OP_ADD, 16'h5556, 1'b0, 1'b0};
        vecs[5]  = '{16'h0005, 16'h0003, 1'b0, OP_SUB, 16'h0002, 1'b1, 1'b0};
        vecs[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, OP_ADD, 16'hFFFF, 1'b1, 1'b0};
        vecs[7]  = '{16'h8000, 16'h8000, 1'b0, OP_ADD, 16'h0000, 1'b1, 1'b1};
        vecs[8]  = '{16'h0000, 16'h0000, 1'b1, OP_SUB, 16'h0000, 1'b1, 1'b0};
        vecs[9]  = '{16'hAAAA, 16'h5555, 1'b1, OP_ADD, 16'h0000, 1'b1, 1'b0};
        vecs[10] = '{16'h7FFF, 16'hFFFF, 1'b0, OP_SUB, 16'h8000, 1'b0, 1'b1};
    endtask

    task automatic test_reset();
        reset = 1'b1; idle16(); idle8(); out_ready16 = 1'b1; out_ready8 = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({out_valid16, sum16, cout16, ovf16} !== 19'd0)
            $display("FAIL reset16: got %b required 0", {out_valid16, sum16, cout16, ovf16});
        checks++;
        if ({out_valid8, sum8, cout8, ovf8} !== 11'd0)
            $display("FAIL reset8: got %b required 0", {out_valid8, sum8, cout8, ovf8});
        if ({out_valid16, sum16, cout16, ovf16} !== 19'd0) errors++;
        if ({out_valid8, sum8, cout8, ovf8} !== 11'd0) errors++;
        reset = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({in_ready16, in_ready8} !== 2'b11) begin
            errors++;
            $display("FAIL reset_in_ready: got %b required 11", {in_ready16, in_ready8});
        end
    endtask

    task automatic test_vectors();
        foreach (vecs[n]) begin
            @(negedge clk); drive16(vecs[n]);
            @(negedge clk); idle16(); #1;
            checks++;
            if (out_valid16 !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d_early: out_valid=%b required 0", n, out_valid16);
            end
            @(negedge clk); #1;
            checks++;
            if ({out_valid16, sum16, cout16, ovf16} !== {1'b1, vecs[n].sum, vecs[n].cout, vecs[n].ovf}) begin
                errors++;
                $display("FAIL vec%0d: got v=%b sum=%h c=%b o=%b required v=1 sum=%h c=%b o=%b",
                         n, out_valid16, sum16, cout16, ovf16, vecs[n].sum, vecs[n].cout, vecs[n].ovf);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c <= 13; c++) begin
            @(negedge clk);
            if (c < 11) drive16(vecs[c]); else idle16();
            #1;
            checks++;
            if (c >= 2 && c - 2 < 11) begin
                if ({out_valid16, sum16, cout16, ovf16} !== {1'b1, vecs[c-2].sum, vecs[c-2].cout, vecs[c-2].ovf}) begin
                    errors++;
                    $display("FAIL b2b_cycle%0d: got v=%b sum=%h c=%b o=%b required v=1 sum=%h",
                             c, out_valid16, sum16, cout16, ovf16, vecs[c-2].sum);
                end
            end else if (out_valid16 !== 1'b0) begin
                errors++;
                $display("FAIL b2b_idle%0d: out_valid=%b required 0", c, out_valid16);
            end
        end
    endtask

    task automatic test_stall();
        @(negedge clk); out_ready16 = 1'b0; drive16(vecs[1]);
        @(negedge clk); drive16(vecs[2]);
        @(negedge clk); idle16();
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if ({out_valid16, sum16, cout16, ovf16, in_ready16} !== {1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold%0d: got v=%b sum=%h c=%b o=%b rdy=%b required v=1 sum=7fff c=1 o=1 rdy=0",
                         c, out_valid16, sum16, cout16, ovf16, in_ready16);
            end
            @(negedge clk);
        end
        out_ready16 = 1'b1; #1;
        checks++;
        if (in_ready16 !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_ready: got %b required 1", in_ready16);
        end
        @(negedge clk); #1;
        checks++;
        if ({out_valid16, sum16, cout16, ovf16} !== {1'b1, 16'hFFFE, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL stall_second: got v=%b sum=%h required v=1 sum=fffe", out_valid16, sum16);
        end
        @(negedge clk); #1;
        checks++;
        if (out_valid16 !== 1'b0) begin
            errors++;
            $display("FAIL stall_nodup: out_valid=%b required 0", out_valid16);
        end
    endtask

    task automatic test_reset_with_valid();
        @(negedge clk); reset = 1'b1; drive16(vecs[4]);
        @(negedge clk); reset = 1'b0; idle16();
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (out_valid16 !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid%0d: out_valid=%b required 0", c, out_valid16);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midflight();
        int lat;
        lat = ksa_latency(32'(MASK8));
        out_ready8 = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            in_valid8 = 1'b1; a8 = 8'(j * 17 + 3); b8 = 8'(j * 5 + 1); cin8 = 1'b0; op8 = OP_ADD;
        end
        @(negedge clk); idle8(); reset = 1'b1; #1;
        checks++;
        if ({out_valid8, sum8} !== {1'b1, 8'h30}) begin
            errors++;
            $display("FAIL midflight_pre: got v=%b sum=%h required v=1 sum=30", out_valid8, sum8);
        end
        @(negedge clk); reset = 1'b0; #1;
        checks++;
        if ({out_valid8, sum8, cout8, ovf8} !== 11'd0) begin
            errors++;
            $display("FAIL midflight_cleared: got %b required 0", {out_valid8, sum8, cout8, ovf8});
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            checks++;
            if (out_valid8 !== 1'b0) begin
                errors++;
                $display("FAIL midflight_stale%0d: out_valid=%b required 0", c, out_valid8);
            end
        end
        @(negedge clk); in_valid8 = 1'b1; a8 = 8'hC8; b8 = 8'h64; cin8 = 1'b1; op8 = OP_ADD;
        for (int d = 1; d < lat; d++) begin
            @(negedge clk); idle8(); #1;
            checks++;
            if (out_valid8 !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_early%0d: out_valid=%b required 0", d, out_valid8);
            end
        end
        @(negedge clk); #1;
        checks++;
        if ({out_valid8, sum8, cout8, ovf8} !== {1'b1, 8'h2D, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_beat: got v=%b sum=%h c=%b o=%b required v=1 sum=2d c=1 o=0",
                     out_valid8, sum8, cout8, ovf8);
        end
    endtask

    task automatic test_sweep8();
        logic [7:0]  btab [16];
        res8_t       q [$];
        res8_t       expv;
        int          idx;
        int          cyc;
        int          total;
        int          sres;
        logic        prev_stall;
        logic [10:0] held;
        logic [8:0]  full;
        btab  = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF,
                  8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h3C, 8'hC3, 8'h10, 8'hEF};
        idx = 0; cyc = 0; total = 256 * 16 * 2; prev_stall = 1'b0; held = '0;
        while ((idx < total || q.size() != 0) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            out_ready8 = 1'($urandom_range(0, 1));
            if (idx < total) begin
                in_valid8 = 1'b1; a8 = idx[7:0]; b8 = btab[idx[11:8]];
                op8 = idx[12]; cin8 = idx[0] ^ idx[5];
            end else begin
                idle8();
            end
            #1;
            checks++;
            if (in_ready8 !== !(out_valid8 && !out_ready8)) begin
                errors++;
                $display("FAIL sweep_in_ready cyc%0d: got %b required %b", cyc, in_ready8, !(out_valid8 && !out_ready8));
            end
            if (prev_stall) begin
                checks++;
                if ({out_valid8, sum8, cout8, ovf8} !== held) begin
                    errors++;
                    $display("FAIL sweep_stall_stable cyc%0d: got %b required %b", cyc, {out_valid8, sum8, cout8, ovf8}, held);
                end
            end
            if (out_valid8 && out_ready8) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL sweep_extra cyc%0d: got sum=%h required no result", cyc, sum8);
                end else begin
                    expv = q.pop_front();
                    if ({sum8, cout8, ovf8} !== expv) begin
                        errors++;
                        $display("FAIL sweep_result cyc%0d: got sum=%h c=%b o=%b required sum=%h c=%b o=%b",
                                 cyc, sum8, cout8, ovf8, expv.sum, expv.cout, expv.ovf);
                    end
                end
            end
            if (in_valid8 && in_ready8) begin
                if (op8 == OP_SUB) begin
                    full = {1'b0, a8} + {1'b0, ~b8} + 9'd1;
                    sres = int'($signed(a8)) - int'($signed(b8));
                end else begin
                    full = {1'b0, a8} + {1'b0, b8} + {8'd0, cin8};
                    sres = int'($signed(a8)) + int'($signed(b8)) + int'(cin8);
                end
                q.push_back('{full[7:0], full[8], (sres > 127 || sres < -128)});
                idx++;
            end
            prev_stall = out_valid8 && !out_ready8;
            held = {out_valid8, sum8, cout8, ovf8};
        end
        idle8(); out_ready8 = 1'b1;
        checks++;
        if (idx != total || q.size() != 0) begin
            errors++;
            $display("FAIL sweep_complete: got issued=%0d pending=%0d required issued=%0d pending=0", idx, q.size(), total);
        end
    endtask

    initial begin
        init_vectors();
        test_reset();
        test_vectors();
        test_back_to_back();
        test_stall();
        test_reset_with_valid();
        test_reset_midflight();
        test_sweep8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipelined_ksa.md
# pipelined_ksa

Parametrised, pipelined Kogge-Stone adder/subtractor, successor to the 16-bit combinational KSA. Generalises operand width, adds an optional pipeline register after any prefix level, an ADD/SUB mode with signed-overflow flag, and a valid/ready handshake on both sides. Sits as the arithmetic core between an operand-issue stage and a result-writeback stage. Sustains one operation per cycle when not stalled.

## Interface
- `WIDTH`, 16: operand width in bits; legal range ≥2; prefix levels `LVL = $clog2(WIDTH)`.
- `REG_MASK`, `{LVL{1'b0}}`: `LVL`-bit mask; bit k=1 inserts a pipeline register after prefix level k (level 0 is the first black/gray level).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand beat offered.
- `in_ready`  out  1  core can accept a beat this cycle.
- `A`  in  WIDTH  operand A.
- `B`  in  WIDTH  operand B.
- `Cin`  in  1  carry in; ignored in SUB mode.
- `Op`  in  1  0 = ADD (A+B+Cin), 1 = SUB (A−B, computed as A+~B+1).
- `out_valid`  out  1  result beat present.
- `out_ready`  in  1  downstream accepts result.
- `Sum`  out  WIDTH  result bits.
- `Cout`  out  1  carry out; in SUB, 1 means no borrow (A ≥ B unsigned).
- `Ovf`  out  1  two's-complement overflow: carry into MSB XOR `Cout`.

## Operation
- Clock is `clk`; reset is synchronous, active-high, port `reset`.
- Stage 0 (input register): on accept (`in_valid && in_ready`), register A, B' = (Op ? ~B : B), c0 = (Op ? 1 : Cin), then form bitwise g = A&B', p = A^B'.
- Prefix levels k = 0..LVL−1, span 2^k: bit i ≥ 2^k combines with bit i−2^k via black cell (G = g_i | p_i&g_j, P = p_i&p_j); bits below span pass through. c0 folded in as generate of a virtual bit −1 (gray cell at bit 0 in pre-level).
- After level k, a register exists iff `REG_MASK[k]`; each register stage carries G, P, original p, and valid.
- Output register: Sum_i = p_i ^ Gc_{i−1} (Gc_{−1} = c0), Cout = Gc_{WIDTH−1}, Ovf = Gc_{WIDTH−2} ^ Gc_{WIDTH−1}; `Ovf` = 0 when WIDTH < 2 is not allowed (elaboration error).
- Results are exact modulo 2^WIDTH; {Cout,Sum} equals A+B+Cin (ADD) or A+~B+1 (SUB) in WIDTH+1 bits.
- Flow control: global stall. `stall = out_valid && !out_ready`. When stall = 1, every pipeline register holds; `in_ready = !stall`. Bubbles are not compressed.
- Ordering: strictly in-order, no drop, no duplication.

## Timing
- Latency accept → `out_valid` = 2 + popcount(REG_MASK) cycles with no stall (input reg + mask regs + output reg). Default mask: 2 cycles.
- Throughput: 1 beat/cycle while `out_ready` = 1.
- `in_ready` is combinational from `out_valid` and `out_ready` only; no path from `in_valid` to `in_ready`.
- `out_valid`/Sum/Cout/Ovf stable while stalled; may change only the cycle after a handshake.
- Reset: all stage valids 0; `out_valid` = 0, Sum = 0, Cout = 0, Ovf = 0; `in_ready` = 1 in the cycle after reset. Data registers also cleared.
- Reset mid-operation: all in-flight beats discarded; no result for them ever appears.
- `in_valid` asserted together with `reset`: beat not accepted.
- Simultaneous output handshake and input accept during full pipeline: both occur, occupancy unchanged.

## Structure
- Package `ksa_pkg`: `OP_ADD`/`OP_SUB` constants, function `ksa_levels(width)` (= $clog2), function `ksa_latency(mask)`.
- Sub-module `ksa_prefix_cell` (black cell; gray when P output unused), instantiated via generate over levels and bits.
- Top holds pre-processing, generate-built prefix network with per-level conditional register, output stage, and stall logic.

## Test plan
- Default params, ADD, A=16'hFFFF, B=16'h0001, Cin=0 → after 2 cycles Sum=16'h0000, Cout=1, Ovf=0.
- SUB, A=16'h8000, B=16'h0001 → Sum=16'h7FFF, Cout=1, Ovf=1; SUB A=3, B=5 → Sum=16'hFFFE, Cout=0, Ovf=0.
- WIDTH=32, REG_MASK=5'b10101, 10k random back-to-back beats, out_ready=1 → latency 5, every result equals 33-bit golden, one result/cycle.
- Random out_ready (50%) over 10k beats → no loss/duplication, order preserved, outputs stable during stall, in_ready low exactly when out_valid && !out_ready.
- Fill pipeline (WIDTH=16, REG_MASK=4'b1111, latency 6), assert reset for 1 cycle → out_valid=0, Sum=0 next cycle, no stale result afterwards; first post-reset beat emerges after 6 cycles.
- WIDTH=8 exhaustive: all 256×256×{Cin 0,1}×{ADD,SUB} → num_wrong = 0.
